uart_tx_fifo: RTL and testbench
===============================

// Module: uart_tx_fifo
// PURPOSE
//   Synthesizable 8N1 UART transmitter with an input FIFO. It serializes bytes that
//   on-chip logic pushes over a valid/ready interface onto the board TX line. It is
//   the DUT-side sender that the UART bus-functional model receives and prints
//   from in simulation.
// PARAMETERS
//   CLK_FREQ    100_000_000  system clock frequency, Hz
//   BAUD        115200       line rate, bits/s
//   FIFO_DEPTH  16           byte FIFO entries; power of 2, >= 2
//   CLKS_PER_BIT (localparam) = CLK_FREQ/BAUD, integer division; must be >= 2
// PORTS
//   clk         in   1    system clock; all logic on rising edge
//   rst_n       in   1    asynchronous, active-low reset
//   tx_data     in   8    byte to send
//   tx_valid    in   1    tx_data is valid
//   tx_ready    out  1    FIFO can accept a byte; equals !full
//   tx          out  1    serial line; idle high
//   busy        out  1    high while a frame is on the line or the FIFO is not empty
//   fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, 0..FIFO_DEPTH
// BEHAVIOUR
//   Reset (async assert, sync release)
//     - tx=1, busy=0, fifo_count=0, tx_ready=1, FSM=IDLE.
//     - Reset mid-frame abandons the frame: tx goes high immediately, FIFO is flushed.
//   Push handshake
//     - A byte is accepted on a clk edge where tx_valid && tx_ready.
//     - tx_ready is purely combinational from the registered count: tx_ready = (count != DEPTH).
//     - When full, no push is accepted, even if a pop occurs on the same edge.
//     - When empty, a push and a pop never coincide, because the pop requires count != 0.
//     - Pointers wrap modulo FIFO_DEPTH.
//     - On a simultaneous push and pop with 0 < count < DEPTH, count is unchanged.
//   FSM: IDLE -> START -> DATA -> STOP
//     - A bit counter counts 0..CLKS_PER_BIT-1; every line bit lasts exactly CLKS_PER_BIT cycles.
//     - IDLE: tx=1. If count != 0: pop the head byte into the shift register, clear the
//       bit counter, and go to START.
//     - START: tx=0 for one bit period, then go to DATA with bit index 0.
//     - DATA: tx = shift[0], LSB first. At the end of each bit: shift right and increment
//       the index. After the 8th bit, go to STOP.
//     - STOP: tx=1 for one bit period. On the last cycle of STOP:
//       - if count != 0, pop and go straight to START (no idle gap; frames are back-to-back,
//         10*CLKS_PER_BIT cycles each);
//       - else go to IDLE.
//   Latency
//     - A push accepted at edge N into an empty FIFO with the FSM in IDLE: pop at edge N+1,
//       tx falls at edge N+2.
//   Output timing and limits
//     - tx is driven from a flop (registered, glitch-free).
//     - busy = (state != IDLE) || (count != 0).
//     - Baud error from integer division is not compensated. The integrator keeps
//       |CLK_FREQ/BAUD - CLKS_PER_BIT| / CLKS_PER_BIT < 2%.
// TESTING (CLK_FREQ=921600, BAUD=115200 -> CLKS_PER_BIT=8; tx looped into UART BFM)
//   1. Reset, then idle 100 cycles -> tx=1, busy=0, tx_ready=1, fifo_count=0 throughout.
//   2. Push 0x55 once -> tx falls 2 edges later; line shows 0,1,0,1,0,1,0,1,0,1 with
//      8 cycles per bit; BFM reports 0x55; busy drops right after the stop bit.
//   3. Push "ABCD" on 4 consecutive cycles -> 4 contiguous frames totalling 320 cycles,
//      with no idle gap; BFM buffer = 0x41424344.
//   4. Hold tx_valid high for 20 pushes (0x00..0x13) while the first frame is in flight
//      -> tx_ready drops when fifo_count=16 and rises after the next pop; all 20 bytes
//      arrive in order, none lost or duplicated.
//   5. Assert rst_n=0 during DATA bit 3 of 0xA5 with 3 bytes queued -> tx=1 in the same
//      cycle, fifo_count=0; after release a push of 0x0D is sent cleanly.
//   6. Push only on cycles where tx_ready=1, using random bytes and random valid gaps
//      over 200 bytes -> a scoreboard of BFM-received bytes equals the pushed sequence.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO over a valid/ready push interface.
// Frames are sent back-to-back while the FIFO holds data; tx idles high.
module uart_tx_fifo #(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [7:0]                   tx_data,
   input  logic                         tx_valid,
   output logic                         tx_ready,
   output logic                         tx,
   output logic                         busy,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned AW           = $clog2(FIFO_DEPTH);
   localparam int unsigned CW           = AW + 1;
   localparam int unsigned BCW          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state_q, state_d;
   logic [BCW-1:0]   baud_q, baud_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic [CW-1:0]    count_q;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [7:0]       mem [FIFO_DEPTH];
   logic             push, pop, bit_done;

   assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
   assign busy       = (state_q != IDLE) || (count_q != '0);
   assign fifo_count = count_q;
   assign tx         = tx_q;
   assign push       = tx_valid && tx_ready;
   assign bit_done   = (baud_q == BCW'(CLKS_PER_BIT - 1));

   // FIFO storage; no reset needed, validity is tracked by count/pointers
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= tx_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         baud_q  <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
      end
   end

   // Next state; tx flop follows the current state, so the line lags the FSM by one cycle
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr_q];
               baud_d  = '0;
               state_d = START;
            end
         end
         START: begin
            tx_d = 1'b0;
            if (bit_done) begin
               baud_d  = '0;
               idx_d   = '0;
               state_d = DATA;
            end else begin
               baud_d = baud_q + BCW'(1);
            end
         end
         DATA: begin
            tx_d = shift_q[0];
            if (bit_done) begin
               baud_d  = '0;
               shift_d = {1'b0, shift_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = STOP;
            end else begin
               baud_d = baud_q + BCW'(1);
            end
         end
         STOP: begin
            if (bit_done) begin
               baud_d = '0;
               if (count_q != '0) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BCW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 8 clocks per bit, with a line receiver
// that decodes frames from tx into a byte queue.
module tb_uart_tx_fifo;

   localparam int unsigned CLK_FREQ = 921600;
   localparam int unsigned BAUD     = 115200;
   localparam int unsigned DEPTH    = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx, busy;
   logic [4:0] fifo_count;

   int n_vec = 0;
   int n_err = 0;
   int rx_ferr = 0;
   logic [7:0] rx_q [$];
   logic [7:0] rx_byte;
   logic       rx_ok;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
   );

   // Line receiver: start detected on a falling negedge sample, bits sampled 3.5 cycles in
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx === 1'b0) begin
            rx_ok   = 1'b1;
            rx_byte = 8'h00;
            for (int c = 1; c <= 75; c++) begin
               @(negedge clk);
               if (rst_n !== 1'b1) begin
                  rx_ok = 1'b0;
                  break;
               end
               if (c % 8 == 3) begin
                  if (c / 8 >= 1 && c / 8 <= 8) rx_byte[c/8-1] = tx;
                  else if (c / 8 == 9 && tx !== 1'b1) rx_ferr++;
               end
            end
            if (rx_ok) rx_q.push_back(rx_byte);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected line level for bit j of a frame (0=start, 1..8=data LSB first, 9=stop)
   function automatic logic line_bit(input logic [7:0] b, input int j);
      logic [7:0] t;
      t = b;
      if (j == 0) return 1'b0;
      if (j >= 9) return 1'b1;
      return t[j-1];
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      tx_valid = 1'b0;
      repeat (3) tick();
      n_vec++;
      if ({tx, busy, tx_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
         n_err++;
         $display("FAIL reset_hold: tx=%b busy=%b ready=%b count=%0d, expected 1 0 1 0",
                  tx, busy, tx_ready, fifo_count);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         n_vec++;
         if ({tx, busy, tx_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
            n_err++;
            $display("FAIL idle cyc %0d: tx=%b busy=%b ready=%b count=%0d, expected 1 0 1 0",
                     i, tx, busy, tx_ready, fifo_count);
         end
      end
   endtask

   // One byte into an idle transmitter, line checked cycle by cycle; e = edges since push
   task automatic send_one_checked(input logic [7:0] b, input string nm);
      rx_q.delete();
      for (int e = 0; e <= 84; e++) begin
         tx_valid = (e == 0);
         tx_data  = b;
         tick();
         if (e == 0) begin
            n_vec++;
            if (fifo_count !== 5'd1) begin
               n_err++;
               $display("FAIL %s count_after_push: got %0d, expected 1", nm, fifo_count);
            end
         end
         if (e == 1) begin
            n_vec++;
            if ({fifo_count, busy, tx} !== {5'd0, 1'b1, 1'b1}) begin
               n_err++;
               $display("FAIL %s after_pop: count=%0d busy=%b tx=%b, expected 0 1 1",
                        nm, fifo_count, busy, tx);
            end
         end
         if (e >= 2 && e <= 81) begin
            n_vec++;
            if (tx !== line_bit(b, (e - 2) / 8)) begin
               n_err++;
               $display("FAIL %s line edge %0d: tx=%b, expected %b", nm, e, tx,
                        line_bit(b, (e - 2) / 8));
            end
         end
         if (e == 80 || e == 81) begin
            n_vec++;
            if (busy !== (e == 80)) begin
               n_err++;
               $display("FAIL %s busy edge %0d: got %b, expected %b", nm, e, busy, (e == 80));
            end
         end
      end
      n_vec++;
      if (rx_q.size() != 1 || rx_q[0] !== b) begin
         n_err++;
         $display("FAIL %s rx_byte: got %0d bytes first=%h, expected 1 byte %h", nm,
                  rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx, b);
      end
   endtask

   task automatic test_single();
      send_one_checked(8'h55, "single");
   endtask

   task automatic test_back_to_back();
      logic [7:0] msg [4];
      int k;
      msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43; msg[3] = 8'h44;
      rx_q.delete();
      for (int e = 0; e <= 325; e++) begin
         tx_valid = (e < 4);
         if (e < 4) tx_data = msg[e];
         tick();
         if (e == 3) begin
            n_vec++;
            if (fifo_count !== 5'd3) begin
               n_err++;
               $display("FAIL b2b count: got %0d, expected 3", fifo_count);
            end
         end
         if (e >= 2 && e <= 321) begin
            k = (e - 2) / 8;
            n_vec++;
            if (tx !== line_bit(msg[k/10], k % 10)) begin
               n_err++;
               $display("FAIL b2b line edge %0d: tx=%b, expected %b", e, tx,
                        line_bit(msg[k/10], k % 10));
            end
         end
         if (e == 320 || e == 321) begin
            n_vec++;
            if (busy !== (e == 320)) begin
               n_err++;
               $display("FAIL b2b busy edge %0d: got %b, expected %b", e, busy, (e == 320));
            end
         end
      end
      n_vec++;
      if (rx_q.size() != 4) begin
         n_err++;
         $display("FAIL b2b rx_count: got %0d, expected 4", rx_q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (rx_q[i] !== msg[i]) begin
               n_err++;
               $display("FAIL b2b rx[%0d]: got %h, expected %h", i, rx_q[i], msg[i]);
            end
         end
      end
   endtask

   task automatic test_full();
      int idx;
      logic acc;
      logic [5:0] exp;
      logic chk;
      idx = 0;
      rx_q.delete();
      for (int e = 0; e <= 245; e++) begin
         tx_valid = (idx < 20);
         tx_data  = 8'(idx);
         acc = tx_valid && tx_ready;
         tick();
         if (acc) idx++;
         chk = 1'b1;
         exp = '0;
         case (e)
            15, 81, 241:     exp = {1'b1, 5'd15};
            16, 80, 82, 242: exp = {1'b0, 5'd16};
            default:         chk = 1'b0;
         endcase
         if (chk) begin
            n_vec++;
            if ({tx_ready, fifo_count} !== exp) begin
               n_err++;
               $display("FAIL full edge %0d: ready=%b count=%0d, expected %b %0d",
                        e, tx_ready, fifo_count, exp[5], exp[4:0]);
            end
         end
      end
      tx_valid = 1'b0;
      n_vec++;
      if (idx != 20) begin
         n_err++;
         $display("FAIL full accepted: got %0d, expected 20", idx);
      end
      for (int i = 0; i < 2000 && busy; i++) tick();
      repeat (4) tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL full drain_timeout: busy=%b, expected 0", busy);
      end
      n_vec++;
      if (rx_q.size() != 20) begin
         n_err++;
         $display("FAIL full rx_count: got %0d, expected 20", rx_q.size());
      end else begin
         for (int i = 0; i < 20; i++) begin
            n_vec++;
            if (rx_q[i] !== 8'(i)) begin
               n_err++;
               $display("FAIL full rx[%0d]: got %h, expected %h", i, rx_q[i], 8'(i));
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] bytes [4];
      bytes[0] = 8'hA5; bytes[1] = 8'h11; bytes[2] = 8'h22; bytes[3] = 8'h33;
      rx_q.delete();
      for (int e = 0; e <= 37; e++) begin
         tx_valid = (e < 4);
         if (e < 4) tx_data = bytes[e];
         tick();
         if (e == 3) begin
            n_vec++;
            if (fifo_count !== 5'd3) begin
               n_err++;
               $display("FAIL rstmid count: got %0d, expected 3", fifo_count);
            end
         end
         if (e == 36) begin
            n_vec++;
            if (tx !== line_bit(8'hA5, 4)) begin
               n_err++;
               $display("FAIL rstmid data_bit3: tx=%b, expected %b", tx, line_bit(8'hA5, 4));
            end
         end
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({tx, busy, tx_ready, fifo_count} !== {1'b1, 1'b0, 1'b1, 5'd0}) begin
         n_err++;
         $display("FAIL rstmid async: tx=%b busy=%b ready=%b count=%0d, expected 1 0 1 0",
                  tx, busy, tx_ready, fifo_count);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (2) tick();
      send_one_checked(8'h0D, "after_rst");
   endtask

   task automatic test_random();
      logic [7:0] exp_q [$];
      logic acc;
      rx_q.delete();
      for (int g = 0; g < 30000 && exp_q.size() < 200; g++) begin
         tx_valid = tx_ready && ($urandom_range(0, 2) != 0);
         tx_data  = 8'($urandom);
         acc = tx_valid;
         tick();
         if (acc) exp_q.push_back(tx_data);
      end
      tx_valid = 1'b0;
      n_vec++;
      if (exp_q.size() != 200) begin
         n_err++;
         $display("FAIL rand pushes: got %0d, expected 200", exp_q.size());
      end
      for (int i = 0; i < 3000 && busy; i++) tick();
      repeat (4) tick();
      n_vec++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL rand drain_timeout: busy=%b, expected 0", busy);
      end
      n_vec++;
      if (rx_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL rand rx_count: got %0d, expected %0d", rx_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_q[i]) begin
               n_err++;
               $display("FAIL rand rx[%0d]: got %h, expected %h", i, rx_q[i], exp_q[i]);
            end
         end
      end
      n_vec++;
      if (rx_ferr != 0) begin
         n_err++;
         $display("FAIL stop_bits: %0d bad stop bits, expected 0", rx_ferr);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_full();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
